// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: checker state encoding and the default PRBS-7 polynomial
// used by both the source-side generator and the receive-side checker.
package prbs_pkg;

  localparam int unsigned PRBS_LFSR_LEN = 7;
  localparam int unsigned PRBS_TAP      = 6;

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    VERIFY = 2'b01,
    LOCKED = 2'b10,
    BAD    = 2'b11
  } prbs_state_e;

endpackage

// File: rtl/prbs_checker_if.sv
// Bit-stream input and status/counter outputs of the PRBS checker.
interface prbs_checker_if #(
  parameter int unsigned CNT_W = 16
);

  logic             rx_bit;
  logic             rx_valid;
  logic             clr_cnt;
  logic             locked;
  logic             win_done;
  logic [CNT_W-1:0] win_errs;
  logic [CNT_W-1:0] tot_bits;
  logic [CNT_W-1:0] tot_errs;
  logic [7:0]       first_byte;
  logic             byte_valid;
  logic [1:0]       state;

  modport master (
    output rx_bit, rx_valid, clr_cnt,
    input  locked, win_done, win_errs, tot_bits, tot_errs, first_byte, byte_valid, state
  );

  modport slave (
    input  rx_bit, rx_valid, clr_cnt,
    output locked, win_done, win_errs, tot_bits, tot_errs, first_byte, byte_valid, state
  );

endinterface

// File: rtl/prbs_lfsr.sv
// Fibonacci PRBS register: loads an external bit (seeding) or free-runs on its own feedback.
module prbs_lfsr #(
  parameter int unsigned LFSR_LEN = prbs_pkg::PRBS_LFSR_LEN,
  parameter int unsigned TAP      = prbs_pkg::PRBS_TAP
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                load,
  input  logic                din,
  output logic                pred_c,
  output logic [LFSR_LEN-1:0] sr_next_c
);

  logic [LFSR_LEN-1:0] sr;

  assign pred_c    = sr[LFSR_LEN-1] ^ sr[TAP-1];
  assign sr_next_c = {sr[LFSR_LEN-2:0], load ? din : pred_c};

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (en) begin
      sr <= sr_next_c;
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: self-synchronises a local replica, declares lock, then counts bit errors
// per measurement window and as saturating totals, and captures the first post-lock byte.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_LEN = PRBS_LFSR_LEN,
  parameter int unsigned TAP      = PRBS_TAP,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned WIN_LEN  = 256,
  parameter int unsigned LOSS_THR = 32,
  parameter int unsigned CNT_W    = 16
) (
  input logic           clk,
  input logic           reset,
  prbs_checker_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(LFSR_LEN + 1);
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);

  prbs_state_e      state_q;
  logic [FILL_W-1:0] fill_q;
  logic [RUN_W-1:0]  run_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  win_err_q;
  logic [CNT_W-1:0]  win_errs_q;
  logic              win_done_q;
  logic [CNT_W-1:0]  tot_bits_q;
  logic [CNT_W-1:0]  tot_errs_q;
  logic [7:0]        cap_q;
  logic [2:0]        cap_cnt_q;
  logic              byte_valid_q;

  logic                pred_c;
  logic [LFSR_LEN-1:0] sr_next_c;
  logic                lfsr_en_c;
  logic                lfsr_load_c;
  logic                err_c;
  logic [RUN_W-1:0]    run_inc_c;
  logic [WIN_W-1:0]    win_cnt_inc_c;
  logic [CNT_W-1:0]    win_err_inc_c;

  // Seed from the line while hunting; free-run on own feedback otherwise.
  always_comb begin
    lfsr_en_c     = bus.rx_valid && (state_q != BAD);
    lfsr_load_c   = (state_q == HUNT);
    err_c         = bus.rx_bit ^ pred_c;
    run_inc_c     = run_q + RUN_W'(1);
    win_cnt_inc_c = win_cnt_q + WIN_W'(1);
    win_err_inc_c = win_err_q + CNT_W'(err_c);
  end

  prbs_lfsr #(
    .LFSR_LEN (LFSR_LEN),
    .TAP      (TAP)
  ) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .en        (lfsr_en_c),
    .load      (lfsr_load_c),
    .din       (bus.rx_bit),
    .pred_c    (pred_c),
    .sr_next_c (sr_next_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HUNT;
      fill_q       <= '0;
      run_q        <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
      win_errs_q   <= '0;
      win_done_q   <= 1'b0;
      tot_bits_q   <= '0;
      tot_errs_q   <= '0;
      cap_q        <= '0;
      cap_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      win_done_q <= 1'b0;
      if (bus.clr_cnt) begin
        tot_bits_q <= '0;
        tot_errs_q <= '0;
      end
      case (state_q)
        HUNT: begin
          if (bus.rx_valid) begin
            // Once the register is full, every further bit re-tests for a non-zero seed.
            if (fill_q >= FILL_W'(LFSR_LEN - 1)) begin
              fill_q <= FILL_W'(LFSR_LEN);
              if (|sr_next_c) begin
                state_q <= VERIFY;
                run_q   <= '0;
              end
            end else begin
              fill_q <= fill_q + FILL_W'(1);
            end
          end
        end
        VERIFY: begin
          if (bus.rx_valid) begin
            if (!err_c) begin
              run_q <= run_inc_c;
              if (run_inc_c == RUN_W'(LOCK_CNT)) begin
                state_q <= LOCKED;
                run_q   <= '0;
              end
            end else begin
              state_q <= HUNT;
              fill_q  <= '0;
              run_q   <= '0;
            end
          end
        end
        LOCKED: begin
          if (bus.rx_valid) begin
            if (!bus.clr_cnt) begin
              if (tot_bits_q != '1) tot_bits_q <= tot_bits_q + CNT_W'(1);
              if (err_c && (tot_errs_q != '1)) tot_errs_q <= tot_errs_q + CNT_W'(1);
            end
            if (!byte_valid_q) begin
              cap_q     <= {cap_q[6:0], bus.rx_bit};
              cap_cnt_q <= cap_cnt_q + 3'd1;
              if (cap_cnt_q == 3'd7) byte_valid_q <= 1'b1;
            end
            if (win_cnt_inc_c == WIN_W'(WIN_LEN)) begin
              win_errs_q <= win_err_inc_c;
              win_done_q <= 1'b1;
              win_cnt_q  <= '0;
              win_err_q  <= '0;
              // Too many errors in a window: drop lock and abandon any partial capture.
              if (win_err_inc_c >= CNT_W'(LOSS_THR)) begin
                state_q <= HUNT;
                fill_q  <= '0;
                if (!byte_valid_q) cap_cnt_q <= '0;
              end
            end else begin
              win_cnt_q <= win_cnt_inc_c;
              win_err_q <= win_err_inc_c;
            end
          end
        end
        BAD: begin
          state_q <= HUNT;
          fill_q  <= '0;
          run_q   <= '0;
        end
      endcase
    end
  end

  assign bus.locked     = (state_q == LOCKED);
  assign bus.state      = state_q;
  assign bus.win_done   = win_done_q;
  assign bus.win_errs   = win_errs_q;
  assign bus.tot_bits   = tot_bits_q;
  assign bus.tot_errs   = tot_errs_q;
  assign bus.first_byte = cap_q;
  assign bus.byte_valid = byte_valid_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker against a bit-level behavioural model of the
// lock / window / totals / capture rules, plus directed scenario checks.
module tb_prbs_checker;

  localparam int LFSR_LEN = 7;
  localparam int TAP      = 6;
  localparam int LOCK_CNT = 16;
  localparam int WIN_LEN  = 256;
  localparam int LOSS_THR = 32;
  localparam int CNT_W    = 16;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prbs_checker_if #(.CNT_W(CNT_W)) bus ();

  prbs_checker dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stimulus generator: PRBS-7 (x^7 + x^6 + 1) as the source would send it.
  logic [6:0] gen;
  task automatic gen_bit(output logic b);
    b   = gen[6] ^ gen[5];
    gen = {gen[5:0], b};
  endtask

  // Reference model: mode 0 hunt, 1 verify, 2 locked; hist = last LFSR_LEN line bits, oldest first.
  int         m_mode, m_fill, m_run, m_win_n, m_win_e, m_win_errs, m_tot_b, m_tot_e;
  bit         m_done, m_bv;
  logic [7:0] m_fb;
  bit         hist[$];
  bit         cap[$];

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_run = 0; m_win_n = 0; m_win_e = 0; m_win_errs = 0;
    m_tot_b = 0; m_tot_e = 0; m_done = 0; m_bv = 0; m_fb = '0;
    hist.delete();
    for (int i = 0; i < LFSR_LEN; i++) hist.push_back(1'b0);
    cap.delete();
  endtask

  task automatic model_step(input bit b, input bit v, input bit c);
    bit p, e, any;
    m_done = 0;
    if (c) begin m_tot_b = 0; m_tot_e = 0; end
    if (!v) return;
    p = hist[0] ^ hist[LFSR_LEN - TAP];
    case (m_mode)
      0: begin
        hist.push_back(b); void'(hist.pop_front());
        if (m_fill < LFSR_LEN) m_fill++;
        any = 0;
        foreach (hist[i]) any |= hist[i];
        if (m_fill == LFSR_LEN && any) begin m_mode = 1; m_run = 0; end
      end
      1: begin
        hist.push_back(p); void'(hist.pop_front());
        if (b == p) begin
          m_run++;
          if (m_run == LOCK_CNT) m_mode = 2;
        end else begin
          m_mode = 0; m_fill = 0; m_run = 0;
        end
      end
      default: begin
        hist.push_back(p); void'(hist.pop_front());
        e = b ^ p;
        m_win_n++;
        m_win_e += int'(e);
        if (!c) begin
          if (m_tot_b < MAXC) m_tot_b++;
          if (e && m_tot_e < MAXC) m_tot_e++;
        end
        if (!m_bv) begin
          cap.push_back(b);
          if (cap.size() == 8) begin
            m_bv = 1;
            foreach (cap[i]) m_fb = {m_fb[6:0], cap[i]};
          end
        end
        if (m_win_n == WIN_LEN) begin
          m_win_errs = m_win_e;
          m_done = 1;
          if (m_win_e >= LOSS_THR) begin
            m_mode = 0; m_fill = 0;
            if (!m_bv) cap.delete();
          end
          m_win_n = 0; m_win_e = 0;
        end
      end
    endcase
  endtask

  task automatic compare_all();
    chk("locked", int'(bus.locked), int'(m_mode == 2));
    chk("state", int'(bus.state), m_mode);
    chk("win_done", int'(bus.win_done), int'(m_done));
    chk("win_errs", int'(bus.win_errs), m_win_errs);
    chk("tot_bits", int'(bus.tot_bits), m_tot_b);
    chk("tot_errs", int'(bus.tot_errs), m_tot_e);
    chk("byte_valid", int'(bus.byte_valid), int'(m_bv));
    if (m_bv) chk("first_byte", int'(bus.first_byte), int'(m_fb));
  endtask

  // One clock: drive inputs, advance the model, sample outputs 1 time unit after the edge.
  task automatic cyc(input logic b, input logic v, input logic c, input logic r);
    bus.rx_bit = b; bus.rx_valid = v; bus.clr_cnt = c; reset = r;
    if (r) model_reset();
    else   model_step(b, v, c);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_bit(input logic inv, output logic sent);
    logic b;
    gen_bit(b);
    sent = b ^ inv;
    cyc(sent, 1'b1, 1'b0, 1'b0);
  endtask

  // Feed the clean stream until lock; inv_at (1-based accepted bit) is inverted, toggle halves valid.
  task automatic run_to_lock(input int inv_at, input bit toggle, output int nbits, output int ncyc);
    logic b;
    nbits = 0; ncyc = 0;
    for (int k = 0; k < 300; k++) begin
      ncyc++;
      if (!toggle || (k % 2 == 0)) begin
        nbits++;
        gen_bit(b);
        cyc(b ^ (nbits == inv_at), 1'b1, 1'b0, 1'b0);
      end else begin
        cyc(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
      end
      if (bus.locked) break;
    end
    if (!bus.locked) chk("lock_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         nb, nc, pulses, cnt, inj, inj_clr, rate;
    bit         mask [WIN_LEN];
    logic       s, any_lock;
    logic [7:0] exp_byte;

    bus.rx_bit = 1'b0; bus.rx_valid = 1'b0; bus.clr_cnt = 1'b0; reset = 1'b1;
    do_reset();
    chk("rst_state", int'(bus.state), 0);

    // Clean stream: lock after 23 bits, one clean window.
    gen = 7'h7F;
    run_to_lock(0, 1'b0, nb, nc);
    chk("t1_lock_bits", nb, LFSR_LEN + LOCK_CNT);
    pulses = 0;
    for (int i = 0; i < WIN_LEN; i++) begin
      send_bit(1'b0, s);
      pulses += int'(bus.win_done);
    end
    chk("t1_pulses", pulses, 1);
    chk("t1_win_done", int'(bus.win_done), 1);
    chk("t1_win_errs", int'(bus.win_errs), 0);
    chk("t1_tot_bits", int'(bus.tot_bits), WIN_LEN);

    // Every 16th bit inverted for three windows, with random idle cycles in between.
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        if ($urandom_range(3, 0) == 0) cyc(1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b0);
        send_bit(i % 16 == 15, s);
      end
      chk("t2_win_errs", int'(bus.win_errs), 16);
      chk("t2_locked", int'(bus.locked), 1);
    end
    chk("t2_tot_errs", int'(bus.tot_errs), 48);

    // 32 random inversions in one window force loss of lock, then relock.
    cnt = 0;
    foreach (mask[i]) mask[i] = 0;
    while (cnt < LOSS_THR) begin
      nb = int'($urandom_range(WIN_LEN - 1, 0));
      if (!mask[nb]) begin mask[nb] = 1; cnt++; end
    end
    for (int i = 0; i < WIN_LEN; i++) send_bit(mask[i], s);
    chk("t3_win_errs", int'(bus.win_errs), LOSS_THR);
    chk("t3_locked", int'(bus.locked), 0);
    chk("t3_state", int'(bus.state), 0);
    run_to_lock(0, 1'b0, nb, nc);
    chk("t3_relock_bits", nb, LFSR_LEN + LOCK_CNT);

    // All-zero input never seeds the replica.
    do_reset();
    any_lock = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      any_lock |= (bus.state != 2'b00);
    end
    chk("t4_zero_hunt", int'(any_lock), 0);
    gen = 7'h7F;
    run_to_lock(0, 1'b0, nb, nc);
    chk("t4_lock_bits", nb, LFSR_LEN + LOCK_CNT);

    // Error on the 12th VERIFY bit restarts the fill.
    do_reset();
    gen = 7'h7F;
    run_to_lock(LFSR_LEN + 12, 1'b0, nb, nc);
    chk("t5_lock_bits", nb, 2 * LFSR_LEN + 12 + LOCK_CNT);

    // Valid every other cycle: same bit count, about twice the clocks.
    do_reset();
    gen = 7'h7F;
    run_to_lock(0, 1'b1, nb, nc);
    chk("t5_toggle_bits", nb, LFSR_LEN + LOCK_CNT);
    chk("t5_toggle_cycles", nc, 2 * (LFSR_LEN + LOCK_CNT) - 1);

    // clr_cnt mid-window: totals restart, window keeps counting.
    inj = 0; inj_clr = 0;
    for (int i = 0; i < 100; i++) begin
      s = 1'b0;
      if (inj < 20 && $urandom_range(19, 0) == 0) begin s = 1'b1; inj++; end
      send_bit(s, s);
    end
    gen_bit(s);
    cyc(s, 1'b1, 1'b1, 1'b0);
    chk("t6_clr_bits", int'(bus.tot_bits), 0);
    chk("t6_clr_errs", int'(bus.tot_errs), 0);
    for (int i = 0; i < WIN_LEN - 101; i++) begin
      s = 1'b0;
      if (inj < 20 && $urandom_range(19, 0) == 0) begin s = 1'b1; inj++; inj_clr++; end
      send_bit(s, s);
    end
    chk("t6_win_done", int'(bus.win_done), 1);
    chk("t6_win_errs", int'(bus.win_errs), inj);
    chk("t6_tot_bits", int'(bus.tot_bits), WIN_LEN - 101);
    chk("t6_tot_errs", int'(bus.tot_errs), inj_clr);

    // Reset in the middle of the first-byte capture, then a full fresh capture.
    do_reset();
    gen = 7'h7F;
    run_to_lock(0, 1'b0, nb, nc);
    for (int i = 0; i < 4; i++) send_bit(1'b0, s);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_locked", int'(bus.locked), 0);
    chk("t6_rst_bv", int'(bus.byte_valid), 0);
    chk("t6_rst_byte", int'(bus.first_byte), 0);
    chk("t6_rst_tot", int'(bus.tot_bits), 0);
    gen = 7'h7F;
    run_to_lock(0, 1'b0, nb, nc);
    exp_byte = '0;
    for (int i = 0; i < 8; i++) begin
      chk("t6_bv_early", int'(bus.byte_valid), 0);
      send_bit(1'b0, s);
      exp_byte = {exp_byte[6:0], s};
    end
    chk("t6_bv", int'(bus.byte_valid), 1);
    chk("t6_first_byte", int'(bus.first_byte), int'(exp_byte));

    // Random soak: gaps, error bursts, clears and occasional resets.
    rate = 64;
    for (int k = 0; k < 2000; k++) begin
      if (k % 256 == 0) rate = ($urandom_range(1, 0) != 0) ? 4 : 64;
      if ($urandom_range(799, 0) == 0) begin
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        gen = 7'h7F;
      end else if ($urandom_range(3, 0) != 0) begin
        gen_bit(s);
        cyc(s ^ ($urandom_range(rate - 1, 0) == 0), 1'b1,
            1'($urandom_range(99, 0) == 0), 1'b0);
      end else begin
        cyc(1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(99, 0) == 0), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-side companion to the PRBS source: checks the decoded bit stream at the output of the convolutional decoder.
- Self-synchronises a local PRBS replica to the incoming bits, declares lock, and then counts bit errors.
- Counts are kept per fixed measurement window and as running totals, so the loopback chain's BER is visible on the board.
- Captures the first post-lock byte for the display path.

Parameters:
- LFSR_LEN, 7, PRBS register length (polynomial x^LFSR_LEN + x^TAP + 1).
- TAP, 6, second feedback tap position (1-based).
- LOCK_CNT, 16, consecutive correct predictions needed to declare lock.
- WIN_LEN, 256, accepted bits per measurement window.
- LOSS_THR, 32, errors within one window that force loss of lock.
- CNT_W, 16, width of window and total counters.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_bit  in  1  decoded data bit.
- rx_valid  in  1  rx_bit qualifier; one bit is accepted per cycle while high.
- clr_cnt  in  1  synchronous clear of the total counters.
- locked  out  1  high while in LOCKED.
- win_done  out  1  one-cycle pulse at each window end.
- win_errs  out  CNT_W  error count of the last completed window.
- tot_bits  out  CNT_W  saturating count of bits checked while LOCKED.
- tot_errs  out  CNT_W  saturating count of errors while LOCKED.
- first_byte  out  8  first 8 bits accepted after lock, MSB = earliest.
- byte_valid  out  1  first_byte is complete.
- state  out  2  current FSM state, for debug.

Behaviour:
- Reset is synchronous. It sets every register and output to 0 and the FSM to HUNT. It overrides all other inputs, including mid-window and mid-capture.
- Cycles with rx_valid=0 change nothing except that win_done returns to 0.
- Prediction: pred = sr[LFSR_LEN-1] ^ sr[TAP-1]. On acceptance sr shifts left; the new bit enters sr[0].
- HUNT (00):
  - Shift rx_bit into sr and increment the fill counter.
  - When the fill counter reaches LOFSR_LEN: go to VERIFY if sr (including the new bit) is non-zero. Otherwise stay in HUNT with the fill counter at LFSR_LEN, so the next bit is re-tested.
- VERIFY (01):
  - The LFSR free-runs, shifting pred rather than rx_bit.
  - rx_bit==pred increments the run counter; reaching LOCK_CNT moves to LOCKED.
  - Any mismatch returns to HUNT and clears the fill and run counters.
- LOCKED (10):
  - The LFSR free-runs. err = rx_bit^pred.
  - Window counter increments; window error counter adds err.
  - tot_bits increments and tot_errs adds err; both saturate at 2^CNT_W-1.
  - On the WIN_LEN-th bit of a window:
    - win_errs is loaded with the window errors, including that bit's error.
    - win_done pulses for one cycle.
    - Window counters clear.
    - If the final window error count is >= LOSS_THR, go to HUNT and clear the fill counter. Totals and first_byte are retained.
- Lock timing: on a clean stream, locked goes high the cycle after the (LFSR_LEN+LOCK_CNT)-th accepted bit, i.e. the 23rd with defaults.
- first_byte capture:
  - Starts with the first bit accepted in LOCKED and shifts MSB-first.
  - byte_valid rises the cycle after the 8th bit; first_byte then holds until reset.
  - A loss of lock during capture abandons the capture. The next lock restarts it.
- clr_cnt:
  - Zeroes tot_bits and tot_errs.
  - If it coincides with an accepted bit, that bit is not counted in the totals but is counted in the window.
  - It has no effect on the FSM, the window counters or win_errs.
- State code 11 is illegal and returns to HUNT on the next cycle.

Decomposition:
- Shared package prbs_pkg holds:
  - state encoding constants HUNT/VERIFY/LOCKED;
  - default PRBS-7 polynomial constants LFSR_LEN=7 and TAP=6, shared with the source-side generator.
- One sub-module, prbs_lfsr:
  - Provides the sr register, pred output and enable.
  - Has a select between loading the external bit and free-running.
  - Is also reusable by the generator.

Test Plan:
- Clean PRBS-7 from seed 7'h7F, rx_valid=1 continuously -> locked rises after bit 23; after 256 more bits win_done pulses once with win_errs=0 and tot_bits=256.
- Invert every 16th bit while locked -> each window reports win_errs=16, locked stays 1, tot_errs=48 after 3 windows.
- 32 bit inversions within one window -> at that window end win_errs=32, locked drops the next cycle, state=HUNT; relock within 23 clean bits.
- All-zero input for 50 bits, then a clean PRBS -> stays in HUNT through the zeros, then locks 23 bits after the PRBS starts.
- Single inversion at bit 12 of VERIFY -> returns to HUNT, fill counter restarts, lock delayed accordingly; rx_valid toggling 1/0 every cycle doubles lock time in clocks, not in bits.
- Pulse clr_cnt mid-window while locked, then pulse reset mid-capture (after 4 bits) -> totals restart from 0 while the window is unaffected; after reset all outputs are 0 and byte_valid=0 until a fresh lock plus 8 bits.
